// File: rtl/frame_write_arbiter.sv
// Arbitrates three draw engines onto one frame-buffer write port, with a one-entry registered output stage.
// Default build: round-robin with bounded burst hold. Define FWA_FIXED_PRIO_EN for fixed priority (req0 highest).
module frame_write_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_we,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  output logic [2:0]          req_ack,
  input  logic                frame_rdy,
  output logic                frame_we,
  output logic [ADDR_W-1:0]   frame_addr,
  output logic [DATA_W-1:0]   frame_data,
  output logic                idle
);
  // Handshake: req i holds req_we/addr/data until req_ack[i]; the stage holds frame_* until frame_rdy.
  logic       stage_open;
  logic       capture;
  logic [1:0] gnt;

  assign stage_open = !frame_we || frame_rdy;
  assign capture    = rst_n && stage_open && (req_we != 3'b000);

`ifdef FWA_FIXED_PRIO_EN
  always_comb begin
    if (req_we[0])      gnt = 2'd0;
    else if (req_we[1]) gnt = 2'd1;
    else                gnt = 2'd2;
  end
`else
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic             owner_vld, owner_vld_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       rr_ptr, rr_ptr_nxt;
  logic [1:0]       rot;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [2:0]       owner_oh;
  logic             owner_req, others_req, hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_vld <= 1'b0;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= '0;
    end else begin
      owner_vld <= owner_vld_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // The owner keeps the grant while under its burst budget, or while nobody else is waiting.
  always_comb begin
    owner_oh   = 3'b001 << owner;
    owner_req  = owner_vld && ((req_we & owner_oh) != 3'b000);
    others_req = (req_we & ~owner_oh) != 3'b000;
    hold       = owner_req && ((burst_cnt < BURST_MAX) || !others_req);
    rot        = 2'd0;
    case (rr_ptr)
      2'd1:    rot = req_we[1] ? 2'd1 : (req_we[2] ? 2'd2 : 2'd0);
      2'd2:    rot = req_we[2] ? 2'd2 : (req_we[0] ? 2'd0 : 2'd1);
      default: rot = req_we[0] ? 2'd0 : (req_we[1] ? 2'd1 : 2'd2);
    endcase
    gnt = hold ? owner : rot;
  end

  always_comb begin
    owner_vld_nxt = owner_vld;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    if (stage_open) begin
      if (req_we == 3'b000) begin
        owner_vld_nxt = 1'b0;
      end else if (hold) begin
        if (burst_cnt < BURST_MAX) burst_cnt_nxt = burst_cnt + CNT_W'(1);
      end else begin
        owner_vld_nxt = 1'b1;
        owner_nxt     = gnt;
        burst_cnt_nxt = CNT_W'(1);
        rr_ptr_nxt    = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_we   <= 1'b0;
      frame_addr <= '0;
      frame_data <= '0;
    end else if (capture) begin
      frame_we   <= 1'b1;
      frame_addr <= req_addr[gnt*ADDR_W +: ADDR_W];
      frame_data <= req_data[gnt*DATA_W +: DATA_W];
    end else if (frame_rdy) begin
      frame_we   <= 1'b0;
    end
  end

  always_comb begin
    req_ack = 3'b000;
    if (capture) req_ack = 3'b001 << gnt;
    idle = !rst_n || (!frame_we && (req_we == 3'b000));
  end
endmodule
